// File: rtl/wavegen_dds_if.sv
// External buses of the DDS: the synchronous waveform ROM and the serial DAC.
// Signal names follow the board-level pin names.
interface wavegen_dds_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10
);
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [DATA_W-1:0] ROM_DATA;
  logic              DAC_CS;
  logic              DAC_SDI;
  logic              DAC_SCK;
  logic              DAC_LD;

  modport master (
    output ROM_ADDR,
    input  ROM_DATA,
    output DAC_CS,
    output DAC_SDI,
    output DAC_SCK,
    output DAC_LD
  );

  modport slave (
    input  ROM_ADDR,
    output ROM_DATA,
    input  DAC_CS,
    input  DAC_SDI,
    input  DAC_SCK,
    input  DAC_LD
  );
endinterface

// File: rtl/wavegen_dds.sv
// Direct digital synthesis waveform generator: phase accumulator, ROM/sawtooth/
// square/triangle sample source, serial DAC shifter with one-deep pending buffer, PWM output.
module wavegen_dds #(
  parameter int DATA_W   = 10,
  parameter int ADDR_W   = 10,
  parameter int PHASE_W  = 16,
  parameter int DIV      = 2500,
  parameter int SCK_HALF = 2
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic [PHASE_W-1:0] FREQ_WORD,
  input  logic [1:0]         MODE,
  wavegen_dds_if.master      bus,
  output logic               PWM_OUT,
  output logic               SAMPLE_STB,
  output logic               OVERRUN
);
  localparam int CNT_W = $clog2(DIV);
  localparam int HC_W  = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [HC_W-1:0]   HC_LAST  = HC_W'(SCK_HALF - 1);
  localparam logic [DATA_W-1:0] PWM_LAST = DATA_W'((1 << DATA_W) - 2);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} spi_state_t;

  logic [CNT_W-1:0]   cnt_reg;
  logic [PHASE_W-1:0] phase_reg;
  logic [PHASE_W-1:0] phase_next;
  logic [ADDR_W-1:0]  rom_addr_reg;
  logic [1:0]         tick_dly_reg;
  logic [DATA_W-1:0]  sample_reg;
  logic [DATA_W-1:0]  sample_next;
  logic [DATA_W-1:0]  tri_bits;
  logic               stb_reg;
  logic               tick;

  spi_state_t         state_reg;
  logic [15:0]        shift_reg;
  logic [15:0]        start_frame;
  logic [4:0]         bit_cnt_reg;
  logic [HC_W-1:0]    hc_reg;
  logic               cs_reg, sck_reg, ld_reg, sdi_reg;
  logic               pend_reg, overrun_reg;
  logic [DATA_W-1:0]  pend_data_reg;

  logic [DATA_W-1:0]  pwm_cnt_reg, pwm_cnt_next;
  logic [DATA_W-1:0]  duty_reg, duty_next;
  logic               pwm_reg;

  // DAC word: control nibble, sample left-justified in a 12-bit data field.
  function automatic logic [15:0] frame_of(input logic [DATA_W-1:0] s);
    logic [11:0] s12;
    s12 = 12'(s) << (12 - DATA_W);
    return {4'b0011, s12};
  endfunction

  assign tick       = ENABLE && (cnt_reg == CNT_LAST);
  assign phase_next = phase_reg + FREQ_WORD;
  assign tri_bits   = phase_reg[PHASE_W-2 -: DATA_W];

  always_comb begin
    sample_next = '0;
    case (MODE)
      2'b00:   sample_next = bus.ROM_DATA;
      2'b01:   sample_next = phase_reg[PHASE_W-1 -: DATA_W];
      2'b10:   sample_next = {DATA_W{~phase_reg[PHASE_W-1]}};
      default: sample_next = phase_reg[PHASE_W-1] ? ~tri_bits : tri_bits;
    endcase
  end

  // Tick at T, phase/address at T+1, ROM data at T+2, sample latched into T+3.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      cnt_reg      <= '0;
      phase_reg    <= '0;
      rom_addr_reg <= '0;
      tick_dly_reg <= '0;
      sample_reg   <= '0;
      stb_reg      <= 1'b0;
    end else begin
      if (ENABLE) cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
      if (tick) begin
        phase_reg    <= phase_next;
        rom_addr_reg <= phase_next[PHASE_W-1 -: ADDR_W];
      end
      tick_dly_reg <= {tick_dly_reg[0], tick};
      stb_reg      <= tick_dly_reg[1];
      if (tick_dly_reg[1]) sample_reg <= sample_next;
    end
  end

  assign start_frame = frame_of(pend_reg ? pend_data_reg : sample_reg);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      hc_reg        <= '0;
      cs_reg        <= 1'b1;
      sck_reg       <= 1'b0;
      ld_reg        <= 1'b1;
      sdi_reg       <= 1'b0;
      pend_reg      <= 1'b0;
      pend_data_reg <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pend_reg || stb_reg) begin
            state_reg   <= SHIFT;
            cs_reg      <= 1'b0;
            sck_reg     <= 1'b0;
            hc_reg      <= '0;
            bit_cnt_reg <= '0;
            sdi_reg     <= start_frame[15];
            shift_reg   <= {start_frame[14:0], 1'b0};
            pend_reg    <= 1'b0;
          end
        end
        SHIFT: begin
          if (hc_reg == HC_LAST) begin
            hc_reg <= '0;
            if (!sck_reg) begin
              // The low half after the 16th falling edge closes the frame.
              if (bit_cnt_reg == 5'd16) begin
                state_reg <= LATCH;
                cs_reg    <= 1'b1;
                ld_reg    <= 1'b0;
                sdi_reg   <= 1'b0;
              end else begin
                sck_reg <= 1'b1;
              end
            end else begin
              sck_reg     <= 1'b0;
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
              sdi_reg     <= shift_reg[15];
              shift_reg   <= {shift_reg[14:0], 1'b0};
            end
          end else begin
            hc_reg <= hc_reg + 1'b1;
          end
        end
        LATCH: begin
          if (hc_reg == HC_LAST) begin
            state_reg <= IDLE;
            ld_reg    <= 1'b1;
            hc_reg    <= '0;
          end else begin
            hc_reg <= hc_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // A strobe arriving while the bus is busy (or a pending frame is being
      // launched this cycle) parks the newest sample; this overrides the clear above.
      if (stb_reg && (state_reg != IDLE || pend_reg)) begin
        pend_data_reg <= sample_reg;
        pend_reg      <= 1'b1;
        if (pend_reg && state_reg != IDLE) overrun_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    pwm_cnt_next = (pwm_cnt_reg == PWM_LAST) ? '0 : pwm_cnt_reg + 1'b1;
    duty_next    = (pwm_cnt_reg == PWM_LAST) ? sample_reg : duty_reg;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      pwm_cnt_reg <= '0;
      duty_reg    <= '0;
      pwm_reg     <= 1'b0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_next;
      duty_reg    <= duty_next;
      pwm_reg     <= (pwm_cnt_next < duty_next);
    end
  end

  assign bus.ROM_ADDR = rom_addr_reg;
  assign bus.DAC_CS   = cs_reg;
  assign bus.DAC_SCK  = sck_reg;
  assign bus.DAC_LD   = ld_reg;
  assign bus.DAC_SDI  = sdi_reg;
  assign PWM_OUT      = pwm_reg;
  assign SAMPLE_STB   = stb_reg;
  assign OVERRUN      = overrun_reg;
endmodule

// File: tb/tb_wavegen_dds.sv
// Directed testbench for wavegen_dds: sample pipeline, waveform sources, DAC framing,
// pending/overrun handling, PWM duty and mid-frame reset.
module tb_wavegen_dds;
  localparam int DATA_W = 10, ADDR_W = 10, PHASE_W = 16, DIV = 4, SCK_HALF = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic [PHASE_W-1:0] freq_word = '0;
  logic [1:0]         mode = 2'b00;
  logic               pwm_out, sample_stb, overrun;
  int checks = 0;
  int failures = 0;

  wavegen_dds_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  wavegen_dds #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PHASE_W(PHASE_W), .DIV(DIV), .SCK_HALF(SCK_HALF)
  ) dut (
    .CLOCK_50(clk), .RESET(rst), .ENABLE(enable), .FREQ_WORD(freq_word), .MODE(mode),
    .bus(bus), .PWM_OUT(pwm_out), .SAMPLE_STB(sample_stb), .OVERRUN(overrun)
  );

  always #10 clk = ~clk;

  // Synchronous ROM model with a recognisable content pattern.
  always @(posedge clk) bus.ROM_DATA <= bus.ROM_ADDR ^ 10'h155;

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_stb(input int bound, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (sample_stb) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Records the next complete frame (CS falling edge through the end of the LD pulse).
  task automatic capture_frame(input int bound, output logic [15:0] f, output int rises,
                               output int ld_low, output int glitches, output bit done);
    logic prev_cs, prev_sck, prev_sdi;
    bit started;
    f = '0; rises = 0; ld_low = 0; glitches = 0; done = 1'b0; started = 1'b0;
    prev_cs = bus.DAC_CS; prev_sck = bus.DAC_SCK; prev_sdi = bus.DAC_SDI;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      if (!started) begin
        started = prev_cs && !bus.DAC_CS;
      end else if (!bus.DAC_CS) begin
        if (!prev_sck && bus.DAC_SCK) begin
          f = {f[14:0], bus.DAC_SDI};
          rises++;
        end
        if (bus.DAC_SDI !== prev_sdi && !(prev_sck && !bus.DAC_SCK)) glitches++;
      end else if (!bus.DAC_LD) begin
        ld_low++;
      end else begin
        done = 1'b1;
        break;
      end
      prev_cs = bus.DAC_CS; prev_sck = bus.DAC_SCK; prev_sdi = bus.DAC_SDI;
    end
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    mode = 2'b01; freq_word = 16'h1234; enable = 1'b1;
    repeat (40) @(posedge clk);
    do_reset();
    got = {bus.DAC_CS, bus.DAC_SCK, bus.DAC_LD, bus.DAC_SDI, overrun, sample_stb, pwm_out,
           |bus.ROM_ADDR};
    exp = 8'b1010_0000;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("FAIL reset_out bit%0d got=%b want=%b", i, got[i], exp[i]);
      end
    end
    $display("reset: outputs=%b", got);
  endtask

  task automatic test_sawtooth();
    int n; bit ok;
    mode = 2'b01; freq_word = 16'h0040; enable = 1'b1;
    wait_stb(20, n, ok);
    checks++;
    if (!ok || n !== 6) begin failures++; $display("FAIL saw_latency got=%0d want=6", n); end
    checks++;
    if (bus.ROM_ADDR !== 10'd1) begin
      failures++; $display("FAIL saw_addr1 got=%h want=001", bus.ROM_ADDR);
    end
    checks++;
    if (dut.sample_reg !== 10'h001) begin
      failures++; $display("FAIL saw_sample1 got=%h want=001", dut.sample_reg);
    end
    wait_stb(20, n, ok);
    checks++;
    if (!ok || n !== 4 || dut.sample_reg !== 10'h002 || bus.ROM_ADDR !== 10'd2) begin
      failures++;
      $display("FAIL saw_sample2 got=%h addr=%h gap=%0d want=002 addr=002 gap=4",
               dut.sample_reg, bus.ROM_ADDR, n);
    end
    // Counter must hold while disabled and resume from where it stopped.
    enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    enable = 1'b1;
    wait_stb(20, n, ok);
    checks++;
    if (!ok || n !== 4 || dut.sample_reg !== 10'h003) begin
      failures++;
      $display("FAIL saw_hold got=%h gap=%0d want=003 gap=4", dut.sample_reg, n);
    end
    $display("sawtooth: third sample=%h", dut.sample_reg);
  endtask

  task automatic test_waveforms();
    logic [1:0]  modes [3] = '{2'b10, 2'b11, 2'b00};
    logic [15:0] freqs [3] = '{16'h8000, 16'h4000, 16'h0140};
    logic [9:0]  exp_s [3][4] = '{'{10'h000, 10'h3FF, 10'h000, 10'h3FF},
                                  '{10'h200, 10'h3FF, 10'h1FF, 10'h000},
                                  '{10'h150, 10'h15F, 10'h15A, 10'h141}};
    logic [9:0]  exp_a [3][4] = '{'{10'h200, 10'h000, 10'h200, 10'h000},
                                  '{10'h100, 10'h200, 10'h300, 10'h000},
                                  '{10'd5, 10'd10, 10'd15, 10'd20}};
    int n; bit ok;
    for (int w = 0; w < 3; w++) begin
      do_reset();
      mode = modes[w]; freq_word = freqs[w]; enable = 1'b1;
      for (int k = 0; k < 4; k++) begin
        wait_stb(20, n, ok);
        checks++;
        if (!ok || dut.sample_reg !== exp_s[w][k] || bus.ROM_ADDR !== exp_a[w][k]) begin
          failures++;
          $display("FAIL wave_m%0d_s%0d got=%h addr=%h want=%h addr=%h", modes[w], k,
                   dut.sample_reg, bus.ROM_ADDR, exp_s[w][k], exp_a[w][k]);
        end
        $display("wave mode=%0d sample%0d=%h addr=%h", modes[w], k, dut.sample_reg,
                 bus.ROM_ADDR);
      end
    end
  endtask

  task automatic test_spi_frame();
    int n, rises, ld_low, glitches; bit ok, done;
    logic [15:0] f;
    do_reset();
    mode = 2'b01; freq_word = 16'hAA80; enable = 1'b1;
    wait_stb(20, n, ok);
    enable = 1'b0;
    checks++;
    if (!ok || dut.sample_reg !== 10'h2AA) begin
      failures++; $display("FAIL spi_sample got=%h want=2aa", dut.sample_reg);
    end
    capture_frame(400, f, rises, ld_low, glitches, done);
    checks++;
    if (!done || f !== 16'h3AA8) begin
      failures++; $display("FAIL spi_bits got=%h want=3aa8 done=%0d", f, done);
    end
    checks++;
    if (rises !== 16) begin failures++; $display("FAIL spi_rises got=%0d want=16", rises); end
    checks++;
    if (ld_low !== 2) begin failures++; $display("FAIL spi_ld got=%0d want=2", ld_low); end
    checks++;
    if (glitches !== 0) begin
      failures++; $display("FAIL spi_sdi_timing got=%0d want=0", glitches);
    end
    $display("spi: frame=%h rises=%0d ld_low=%0d", f, rises, ld_low);
  endtask

  task automatic test_overrun();
    int n, rises, ld_low, glitches; bit ok, done;
    logic [15:0] f;
    do_reset();
    mode = 2'b01; freq_word = 16'h0040; enable = 1'b1;
    for (int k = 0; k < 3; k++) wait_stb(20, n, ok);
    checks++;
    if (!ok || overrun !== 1'b0) begin
      failures++; $display("FAIL ovr_early got=%b want=0", overrun);
    end
    enable = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b want=1", overrun); end
    capture_frame(400, f, rises, ld_low, glitches, done);
    checks++;
    if (!done || f !== 16'h300C || rises !== 16) begin
      failures++;
      $display("FAIL ovr_newest got=%h rises=%0d want=300c rises=16", f, rises);
    end
    capture_frame(200, f, rises, ld_low, glitches, done);
    checks++;
    if (done) begin failures++; $display("FAIL ovr_extra_frame got=%h want=none", f); end
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
    $display("overrun: flag=%b", overrun);
  endtask

  task automatic test_pwm();
    logic [1:0]  modes [3] = '{2'b10, 2'b10, 2'b01};
    logic [15:0] freqs [3] = '{16'h0000, 16'h8000, 16'h0000};
    int          highs [3] = '{1023, 0, 512};
    int n, cnt; bit ok;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      mode = modes[p]; freq_word = freqs[p]; enable = 1'b1;
      wait_stb(20, n, ok);
      enable = 1'b0;
      checks++;
      if (!ok) begin failures++; $display("FAIL pwm_stb%0d got=timeout want=strobe", p); end
      if (p == 0) begin
        cnt = 0;
        for (int i = 0; i < 900; i++) begin @(posedge clk); #1; cnt += int'(pwm_out); end
        checks++;
        if (cnt !== 0) begin
          failures++; $display("FAIL pwm_before_wrap got=%0d want=0", cnt);
        end
        repeat (200) @(posedge clk);
      end else begin
        repeat (1100) @(posedge clk);
      end
      #1;
      cnt = 0;
      for (int i = 0; i < 1023; i++) begin @(posedge clk); #1; cnt += int'(pwm_out); end
      checks++;
      if (cnt !== highs[p]) begin
        failures++; $display("FAIL pwm_duty%0d got=%0d want=%0d", p, cnt, highs[p]);
      end
      $display("pwm: sample=%h high=%0d/1023", dut.sample_reg, cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int rises, lows;
    logic prev_sck;
    logic [7:0] got;
    do_reset();
    mode = 2'b01; freq_word = 16'h1240; enable = 1'b1;
    rises = 0;
    prev_sck = bus.DAC_SCK;
    for (int i = 0; i < 200 && rises < 7; i++) begin
      @(posedge clk);
      #1;
      if (!bus.DAC_CS && !prev_sck && bus.DAC_SCK) rises++;
      prev_sck = bus.DAC_SCK;
    end
    checks++;
    if (rises !== 7 || overrun !== 1'b1) begin
      failures++; $display("FAIL mid_setup got=rises%0d ovr%b want=rises7 ovr1", rises, overrun);
    end
    rst = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    got = {bus.DAC_CS, bus.DAC_SCK, bus.DAC_LD, bus.DAC_SDI, overrun, sample_stb,
           |bus.ROM_ADDR, |dut.sample_reg};
    rst = 1'b0;
    checks++;
    if (got !== 8'b1010_0000) begin
      failures++; $display("FAIL mid_reset got=%b want=10100000", got);
    end
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      #1;
      lows += int'(!bus.DAC_LD) + int'(!bus.DAC_CS);
    end
    checks++;
    if (lows !== 0) begin failures++; $display("FAIL mid_no_latch got=%0d want=0", lows); end
    $display("reset mid-frame: outputs=%b", got);
  endtask

  initial begin
    do_reset();
    test_reset();
    test_sawtooth();
    test_waveforms();
    test_spi_frame();
    test_overrun();
    test_pwm();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wavegen_dds.md
WAVEGEN_DDS -- requirements
Module: wavegen_dds

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 10, sample/DAC width (1..12); ADDR_W, 10, ROM address width; PHASE_W, 16, phase accumulator width (>= DATA_W+1 and >= ADDR_W); DIV, 2500, sample-tick period in clocks (>= 2); SCK_HALF, 2, SPI SCK half-period in clocks (>= 1).
REQ-002 Ports (name, direction, width, meaning): CLOCK_50 in 1 system clock; RESET in 1 synchronous active-high reset.
REQ-003 ENABLE in 1: sample-tick enable.
REQ-004 FREQ_WORD in PHASE_W: phase increment per tick.
REQ-005 MODE in 2: 00 ROM, 01 sawtooth, 10 square, 11 triangle.
REQ-006 ROM_ADDR out ADDR_W: registered address to an external synchronous ROM.
REQ-007 ROM_DATA in DATA_W: ROM output, valid one clock after ROM_ADDR changes.
REQ-008 DAC_CS, DAC_SDI, DAC_SCK, DAC_LD out 1 each: serial DAC bus (CS and LD active-low).
REQ-009 PWM_OUT out 1: PWM of current sample.
REQ-010 SAMPLE_STB out 1: one-clock pulse when sample register updates.
REQ-011 OVERRUN out 1: sticky, set when a pending sample is overwritten; cleared only by RESET.

Function
REQ-012 Tick counter counts 0..DIV-1 while ENABLE=1, holds while ENABLE=0; tick = 1 for the clock in which count==DIV-1 and ENABLE=1; count wraps to 0.
REQ-013 On tick, phase <= (phase + FREQ_WORD) mod 2^PHASE_W; FREQ_WORD sampled only then.
REQ-014 ROM_ADDR = top ADDR_W bits of phase, registered; valid the clock after the phase update.
REQ-015 Sample register latches 3 clocks after tick (T+1 phase, T+2 ROM_DATA valid, T+3 latch); SAMPLE_STB high in the clock after the latch edge.
REQ-016 Sample source: ROM -> ROM_DATA; sawtooth -> phase[PHASE_W-1 -: DATA_W]; square -> all-ones if phase MSB=0, else 0; triangle -> phase[PHASE_W-2 -: DATA_W] if MSB=0, else its bitwise inverse.
REQ-017 MODE sampled at the latch edge; a change affects only subsequent samples.
REQ-018 SPI FSM states IDLE, SHIFT, LATCH; frame 16 bits MSB-first = {4'b0011, sample, (12-DATA_W) zeros}.
REQ-019 IDLE: DAC_CS=1, DAC_SCK=0, DAC_LD=1, DAC_SDI=0; on SAMPLE_STB or pending flag -> SHIFT, DAC_CS=0 next clock, first bit on DAC_SDI.
REQ-020 SHIFT: DAC_SCK toggles every SCK_HALF clocks starting low; DAC_SDI changes only on falling SCK; after 16th rising edge and following low half-period -> LATCH, DAC_CS=1.
REQ-021 LATCH: DAC_LD=0 for exactly SCK_HALF clocks, then IDLE.
REQ-022 SAMPLE_STB while not IDLE: sample stored in one-deep pending register, pending flag set; if pending already set, value overwritten (newest wins) and OVERRUN set.
REQ-023 Pending frame starts in the clock IDLE is entered; pending flag clears at that start.
REQ-024 ENABLE=0 mid-frame: frame and any pending frame complete normally.
REQ-025 PWM counter free-runs 0..2^DATA_W-2 (period 2^DATA_W-1); PWM_OUT = (count < duty).
REQ-026 Duty loads from sample register only when counter wraps to 0; sample 0 -> always low, all-ones -> always high.

Reset
REQ-027 RESET at a clock edge, in any state including mid-frame: tick count 0, phase 0, ROM_ADDR 0, sample 0, duty 0, pending 0, OVERRUN 0, FSM IDLE, DAC_CS=1, DAC_SCK=0, DAC_LD=1, DAC_SDI=0, PWM_OUT=0, SAMPLE_STB=0, all valid the next clock.

Verification
REQ-028 DIV=4, MODE=01, FREQ_WORD=0x0040, ENABLE=1 after reset -> first tick phase=0x0040, ROM_ADDR=1, sample=0x001, SAMPLE_STB 3 clocks after tick; second sample 0x002.
REQ-029 Sample 0x2AA, SCK_HALF=2 -> DAC_CS low for 16 SCK periods, SDI bits 0011_1010101010_00 on rising edges, DAC_LD low 2 clocks after CS rises.
REQ-030 MODE=10, FREQ_WORD=0x8000 -> phase alternates 0x8000/0x0000, samples alternate 0x000/0x3FF (wrap check).
REQ-031 Sample 0 / 0x3FF / 0x200 held -> PWM_OUT high 0 / 1023 / 512 of 1023 clocks per period; duty change only at counter wrap.
REQ-032 DIV=8, SCK_HALF=4, incrementing samples -> mid-frame samples stored pending, overwritten ones flagged by OVERRUN=1, frame after current carries the newest sample.
REQ-033 RESET asserted at SHIFT bit 7 -> next clock DAC_CS=1, DAC_SCK=0, DAC_LD=1, OVERRUN=0, no LATCH pulse.
